reg_load_arbiter: RTL and testbench

// - Shares one 4-bit parallel-load register (falling-edge capture, ld/d/q) between N_REQ requesters.
// - Round-robin arbitration; drives the register's ld/d; returns a one-cycle ack to the winner.
// - Controller state updates on rising clk, so ld/d are stable half a cycle before the register's falling-edge capture.

---
 rtl/reg_load_arbiter_pkg.sv | 16 +
 rtl/reg_load_arbiter_if.sv | 30 +++
 rtl/reg_load_arbiter_rr_pick.sv | 36 +++
 rtl/reg_load_arbiter.sv | 138 +++++++++++++
 tb/tb_reg_load_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_load_arbiter_pkg.sv
// Purpose: shared types and defaults for the reg_load_arbiter slice (FSM state encoding, sizes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ACK  = 2'b10
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 4;
    localparam int IDW_DEF   = 2;

endpackage

// File: rtl/reg_load_arbiter_if.sv
// Purpose: requester-side bundle of the load arbiter plus the drive lines to the shared register.
// Latency: n/a (wiring only); optional readback ports under REG_LOAD_ARBITER_SHADOW_EN.
// Backpressure: req is a level held until ack; the arbiter never stalls a granted load.
interface reg_load_arbiter_if
    import reg_load_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int IDW   = IDW_DEF
) ();

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    ack;
    logic                ld;
    logic [DW-1:0]       d;
    logic                busy;
    logic [IDW-1:0]      grant_id;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
    logic [DW-1:0]       shadow_q;
    logic [IDW-1:0]      shadow_id;

    modport slave  (input  req, req_data, output ack, ld, d, busy, grant_id, shadow_q, shadow_id);
    modport master (output req, req_data, input  ack, ld, d, busy, grant_id, shadow_q, shadow_id);
`else
    modport slave  (input  req, req_data, output ack, ld, d, busy, grant_id);
    modport master (output req, req_data, input  ack, ld, d, busy, grant_id);
`endif

endinterface

// File: rtl/reg_load_arbiter_rr_pick.sv
// Purpose: combinational round-robin priority encoder: first set req bit at or after rr_ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid simply reflects whether any request is set.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    // one spare bit so rr_ptr + offset never overflows before the wrap
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

    logic [IDW:0] cand;

    // scan offsets 0..N_REQ-1 from the pointer; the first hit wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!valid && req[cand[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Purpose: round-robin share of one falling-edge parallel-load register; optional readback via REG_LOAD_ARBITER_SHADOW_EN.
// Latency: req seen in IDLE -> ld next cycle -> one-hot ack the cycle after; one grant per 3 cycles at best.
// Backpressure: requesters hold req/data until ack; requests arriving during LOAD/ACK wait for IDLE.
module reg_load_arbiter
    import reg_load_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int IDW   = IDW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_load_arbiter_if.slave    bus
);

    if ((1 << IDW) < N_REQ) begin : g_bad_idw
        $error("reg_load_arbiter: IDW too narrow for N_REQ");
    end

    state_e                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]         gid_q, gid_d;
    logic                   ld_q, ld_d;
    logic [DW-1:0]          d_q, d_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic                   busy_q, busy_d;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
    logic [DW-1:0]          shadow_q_q, shadow_q_d;
    logic [IDW-1:0]         shadow_id_q, shadow_id_d;
`endif

    logic                   pick_vld;
    logic [IDW-1:0]         pick_idx;
    logic [DW-1:0]          slot [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        assign slot[gi] = bus.req_data[gi*DW +: DW];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    // next state and registered outputs; defaults hold everything
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        ld_d     = ld_q;
        d_d      = d_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
        shadow_q_d  = shadow_q_q;
        shadow_id_d = shadow_id_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    // data sampled only here; later req_data changes cannot disturb the load
                    state_d = LOAD;
                    ld_d    = 1'b1;
                    d_d     = slot[pick_idx];
                    gid_d   = pick_idx;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d      = ACK;
                ld_d         = 1'b0;
                ack_d        = '0;
                ack_d[gid_q] = 1'b1;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
                shadow_q_d  = d_q;
                shadow_id_d = gid_q;
`endif
            end
            ACK: begin
                state_d  = IDLE;
                ack_d    = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (gid_q == IDW'(N_REQ-1)) ? '0 : gid_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                ld_d    = 1'b0;
                ack_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and output registers; reset drops ld immediately, aborting any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            ld_q     <= 1'b0;
            d_q      <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
            shadow_q_q  <= '0;
            shadow_id_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            ld_q     <= ld_d;
            d_q      <= d_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
            shadow_q_q  <= shadow_q_d;
            shadow_id_q <= shadow_id_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.ld       = ld_q;
    assign bus.d        = d_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = gid_q;
`ifdef REG_LOAD_ARBITER_SHADOW_EN
    assign bus.shadow_q  = shadow_q_q;
    assign bus.shadow_id = shadow_id_q;
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Purpose: directed, table-driven bench for reg_load_arbiter with a falling-edge register model on ld/d.
// Latency: expects ld one cycle after a request is seen in IDLE and ack one cycle later.
// Backpressure: requesters hold req until ack, then drop it (except where a test holds it deliberately).
module tb_reg_load_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    logic [3:0] q;

    reg_load_arbiter_if #(.N_REQ(4), .DW(4), .IDW(2)) bus ();

    reg_load_arbiter #(.N_REQ(4), .DW(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the shared 4-bit register: captures d on the falling edge when ld is high
    always @(negedge clk) begin
        if (bus.ld) q <= bus.d;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        int          gid;
        logic [3:0]  dexp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // wait (bounded) for a negedge where ld is high
    task automatic wait_ld(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ld && n < 20);
        chk({nm, "_ld_seen"}, int'(bus.ld), 1);
    endtask

    // one grant: LOAD cycle checks, then ACK cycle checks; optionally drop the winner's req
    task automatic serve(input string nm, input int gid_exp, input logic [3:0] d_exp,
                         input bit drop, output int ld_cyc);
        logic [3:0] oh;
        wait_ld(nm);
        ld_cyc = cyc;
        chk({nm, "_gid"}, int'(bus.grant_id), gid_exp);
        chk({nm, "_d"}, int'(bus.d), int'(d_exp));
        chk({nm, "_busy_load"}, int'(bus.busy), 1);
        chk({nm, "_ack_load"}, int'(bus.ack), 0);
        @(negedge clk);
        oh = 4'b0000;
        oh[gid_exp] = 1'b1;
        chk({nm, "_ack"}, int'(bus.ack), int'(oh));
        chk({nm, "_ld_off"}, int'(bus.ld), 0);
        chk({nm, "_q"}, int'(q), int'(d_exp));
`ifdef REG_LOAD_ARBITER_SHADOW_EN
        chk({nm, "_shadow_q"}, int'(bus.shadow_q), int'(d_exp));
        chk({nm, "_shadow_id"}, int'(bus.shadow_id), gid_exp);
`endif
        if (drop) bus.req[gid_exp] = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ld"}, int'(bus.ld), 0);
        chk({nm, "_d"}, int'(bus.d), 0);
        chk({nm, "_ack"}, int'(bus.ack), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_gid"}, int'(bus.grant_id), 0);
`ifdef REG_LOAD_ARBITER_SHADOW_EN
        chk({nm, "_shadow_q"}, int'(bus.shadow_q), 0);
        chk({nm, "_shadow_id"}, int'(bus.shadow_id), 0);
`endif
    endtask

    initial begin
        int t0, t1, tr;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;

        // rr_ptr evolves across rows: 0 ->1 ->0 ->2 ->1 ->3 ->0 ->3 ->1
        tbl[0] = '{req: 4'b0001, data: 16'h000A, gid: 0, dexp: 4'hA};
        tbl[1] = '{req: 4'b1000, data: 16'h7000, gid: 3, dexp: 4'h7};
        tbl[2] = '{req: 4'b0110, data: 16'h0C50, gid: 1, dexp: 4'h5};
        tbl[3] = '{req: 4'b0011, data: 16'h0021, gid: 0, dexp: 4'h1};
        tbl[4] = '{req: 4'b1100, data: 16'hFE00, gid: 2, dexp: 4'hE};
        tbl[5] = '{req: 4'b1111, data: 16'h4321, gid: 3, dexp: 4'h4};
        tbl[6] = '{req: 4'b0100, data: 16'h0300, gid: 2, dexp: 4'h3};
        tbl[7] = '{req: 4'b0101, data: 16'h0809, gid: 0, dexp: 4'h9};

        #3;
        chk_reset_vals("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.req_data = tbl[i].data;
            bus.req      = tbl[i].req;
            serve($sformatf("vec%0d", i), tbl[i].gid, tbl[i].dexp, 1'b1, t0);
            bus.req = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_busy_idle", i), int'(bus.busy), 0);
        end

        // synchronous-style reset pulse to bring rr_ptr back to 0
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst1");
        @(negedge clk);
        rst_n = 1'b1;

        // all four requesting from rr_ptr=0: grants 0,1,2,3, three cycles apart
        bus.req_data = 16'h4321;
        bus.req      = 4'b1111;
        tr = 0;
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("rr%0d", k), k, 4'(k + 1), 1'b1, t1);
            if (k > 0) chk($sformatf("rr%0d_spacing", k), t1 - tr, 3);
            tr = t1;
        end
        @(negedge clk);
        chk("rr_busy_idle", int'(bus.busy), 0);

        // fairness: req0 held, req2 raised during requester 0's LOAD
        bus.req_data = 16'h0601;
        bus.req      = 4'b0001;
        wait_ld("fair0");
        chk("fair0_gid", int'(bus.grant_id), 0);
        bus.req[2] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk("fair0_ack", int'(bus.ack), 1);
        serve("fair2", 2, 4'h6, 1'b1, t1);
        chk("fair2_within6", int'((t1 - t0) <= 6), 1);
        serve("fair0b", 0, 4'h1, 1'b1, t1);
        bus.req = '0;
        @(negedge clk);

        // data change during LOAD must not affect the captured value
        bus.req_data = 16'h0050;
        bus.req      = 4'b0010;
        wait_ld("dchg");
        chk("dchg_gid", int'(bus.grant_id), 1);
        bus.req_data[7:4] = 4'h9;
        chk("dchg_d_load", int'(bus.d), 5);
        @(negedge clk);
        chk("dchg_q", int'(q), 5);
        chk("dchg_ack", int'(bus.ack), 4'b0010);
        chk("dchg_d_ack", int'(bus.d), 5);
        bus.req = '0;
        @(negedge clk);

        // async reset mid-LOAD (rr_ptr is 2 here, so requester 3 wins)
        bus.req_data = 16'h8000;
        bus.req      = 4'b1000;
        wait_ld("arst");
        chk("arst_gid", int'(bus.grant_id), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ld_async", int'(bus.ld), 0);
        chk("arst_busy_async", int'(bus.busy), 0);
        @(negedge clk);
        chk("arst_ack_held", int'(bus.ack), 0);
        bus.req = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("arst_ack_after", int'(bus.ack), 0);
        chk("arst_ld_after", int'(bus.ld), 0);
        chk("arst_busy_after", int'(bus.busy), 0);
        // rr_ptr back to 0: with everyone requesting, requester 0 must win
        bus.req_data = 16'h4321;
        bus.req      = 4'b1111;
        serve("arst_rr", 0, 4'h1, 1'b1, t1);
        bus.req = '0;
        @(negedge clk);
        chk("final_busy", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
